// File: rtl/branch_pred_pkg.sv
// Shared types and constants for the branch predictor controller.
package branch_pred_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    PREDICT = 2'd2,
    UPDATE  = 2'd3
  } bp_state_e;

  // 2-bit saturating counter encodings
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // Next value of a 2-bit counter: taken counts up to ST, not-taken down to SNT.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2**IDX_W two-bit counters, async read, saturating write.
module bp_pht
  import branch_pred_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_rd_ctr,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  logic [1:0] r_table [2**IDX_W];

  assign o_rd_ctr = r_table[i_rd_idx];

  // Reset every entry to weakly-not-taken; otherwise train the addressed entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**IDX_W; i++) r_table[i] <= WNT;
    end else if (i_wr_en) begin
      r_table[i_wr_idx] <= sat_update(r_table[i_wr_idx], i_wr_taken);
    end
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Gshare-style branch predictor controller: one frame per data_input_done
// rising edge, walked through LOOKUP -> PREDICT -> UPDATE.
//
//   state   | meaning
//   IDLE    | waiting for a frame edge
//   LOOKUP  | index = addr ^ GHR, counter read and latched
//   PREDICT | prediction strobe on the outputs
//   UPDATE  | train counter, shift GHR, bump statistics
module branch_pred_ctrl
  import branch_pred_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 4,
  parameter int HIST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_input_done,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              direction_ground_truth,
  output logic              pred_valid,
  output logic              pred_dir,
  output logic              mispredict,
  output logic              busy,
  output logic              dropped,
  output logic [15:0]       total_cnt,
  output logic [15:0]       correct_cnt
);

  bp_state_e         r_state;
  logic              r_done_q;
  logic [ADDR_W-1:0] r_addr;
  logic              r_truth;
  logic [HIST_W-1:0] r_ghr;
  logic [IDX_W-1:0]  r_idx;
  logic [1:0]        r_ctr;
  logic              r_pred_valid;
  logic              r_pred_dir;
  logic              r_mispredict;
  logic              r_dropped;
  logic [15:0]       r_total_cnt;
  logic [15:0]       r_correct_cnt;

  logic              w_edge;
  logic [IDX_W-1:0]  w_lookup_idx;
  logic [1:0]        w_rd_ctr;
  logic              w_wr_en;
  logic              w_miss;
  logic              w_unused_addr;

  assign w_edge        = data_input_done & ~r_done_q;
  assign w_lookup_idx  = r_addr[IDX_W-1:0] ^ IDX_W'(r_ghr);
  assign w_wr_en       = (r_state == UPDATE);
  assign w_miss        = r_ctr[1] ^ r_truth;
  // Only the low IDX_W address bits feed the index; the rest is kept for visibility.
  assign w_unused_addr = ^r_addr;

  bp_pht #(.IDX_W(IDX_W)) u_pht (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (w_lookup_idx),
    .o_rd_ctr   (w_rd_ctr),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (r_idx),
    .i_wr_taken (r_truth)
  );

  // Frame FSM with history, statistics and registered prediction outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_done_q      <= 1'b0;
      r_addr        <= '0;
      r_truth       <= 1'b0;
      r_ghr         <= '0;
      r_idx         <= '0;
      r_ctr         <= '0;
      r_pred_valid  <= 1'b0;
      r_pred_dir    <= 1'b0;
      r_mispredict  <= 1'b0;
      r_dropped     <= 1'b0;
      r_total_cnt   <= '0;
      r_correct_cnt <= '0;
    end else begin
      r_done_q     <= data_input_done;
      r_pred_valid <= 1'b0;
      r_pred_dir   <= 1'b0;
      r_mispredict <= 1'b0;
      if (w_edge && r_state != IDLE) r_dropped <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_edge) begin
            r_addr  <= inst_addr;
            r_truth <= direction_ground_truth;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_idx        <= w_lookup_idx;
          r_ctr        <= w_rd_ctr;
          r_pred_valid <= 1'b1;
          r_pred_dir   <= w_rd_ctr[1];
          r_mispredict <= w_rd_ctr[1] ^ r_truth;
          r_state      <= PREDICT;
        end
        PREDICT: begin
          r_state <= UPDATE;
        end
        UPDATE: begin
          r_ghr <= (r_ghr << 1) | HIST_W'(r_truth);
          if (r_total_cnt != 16'hFFFF) r_total_cnt <= r_total_cnt + 16'd1;
          if (!w_miss && r_correct_cnt != 16'hFFFF) r_correct_cnt <= r_correct_cnt + 16'd1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs forced low while reset is held, even before the reset edge lands.
  always_comb begin
    pred_valid  = ~rst & r_pred_valid;
    pred_dir    = ~rst & r_pred_dir;
    mispredict  = ~rst & r_mispredict;
    busy        = ~rst & (r_state != IDLE);
    dropped     = ~rst & r_dropped;
    total_cnt   = rst ? 16'd0 : r_total_cnt;
    correct_cnt = rst ? 16'd0 : r_correct_cnt;
  end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl with hand-computed expectations.
module tb_branch_pred_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_input_done;
  logic [15:0] inst_addr;
  logic        direction_ground_truth;
  logic        pred_valid;
  logic        pred_dir;
  logic        mispredict;
  logic        busy;
  logic        dropped;
  logic [15:0] total_cnt;
  logic [15:0] correct_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  branch_pred_ctrl #(.ADDR_W(16), .IDX_W(4), .HIST_W(4)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .data_input_done        (data_input_done),
    .inst_addr              (inst_addr),
    .direction_ground_truth (direction_ground_truth),
    .pred_valid             (pred_valid),
    .pred_dir               (pred_dir),
    .mispredict             (mispredict),
    .busy                   (busy),
    .dropped                (dropped),
    .total_cnt              (total_cnt),
    .correct_cnt            (correct_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic do_reset();
    rst = 1'b1;
    data_input_done = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One frame: edge, then watch five cycles. lat = cycles after capture edge.
  task automatic run_frame(input logic [15:0] a, input logic t,
                           output int pulses, output int lat,
                           output logic pd, output logic mp);
    pulses = 0; lat = -1; pd = 1'b0; mp = 1'b0;
    inst_addr = a;
    direction_ground_truth = t;
    data_input_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_input_done = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (pred_valid) begin
        pulses++;
        if (lat < 0) lat = c;
        pd = pred_dir;
        mp = mispredict;
      end
      @(negedge clk);
    end
  endtask

  // Accepted edge followed by a second edge landing drop_c cycles later.
  task automatic drop_frame(input int drop_c, output int pulses);
    pulses = 0;
    inst_addr = 16'h0003;
    direction_ground_truth = 1'b1;
    data_input_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_input_done = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (pred_valid) pulses++;
      data_input_done = (c == drop_c);
      @(negedge clk);
    end
    data_input_done = 1'b0;
  endtask

  int          pulses, lat;
  logic        pd, mp;
  logic [3:0]  exp_idx [4];
  logic [3:0]  exp_ghr [4];
  logic [15:0] sat_addr [5];
  logic        sat_pd [5];
  logic [1:0]  sat_ctr [5];

  initial begin
    exp_idx  = '{4'h0, 4'h1, 4'h3, 4'h7};
    exp_ghr  = '{4'h1, 4'h3, 4'h7, 4'hF};
    sat_addr = '{16'h0005, 16'h0004, 16'h0006, 16'h0002, 16'h000A};
    sat_pd   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    sat_ctr  = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    rst = 1'b1;
    data_input_done = 1'b0;
    inst_addr = '0;
    direction_ground_truth = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_busy", 32'(busy), 32'd0);
    check("rst_hold_valid", 32'(pred_valid), 32'd0);
    check("rst_hold_total", 32'(total_cnt), 32'd0);
    do_reset();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_dropped", 32'(dropped), 32'd0);
    check("reset_correct", 32'(correct_cnt), 32'd0);
    check("reset_ghr", 32'(dut.r_ghr), 32'd0);
    check("reset_entry3", 32'(dut.u_pht.r_table[3]), 32'd1);

    // First frame after reset: addr 3 taken, WNT entry predicts not-taken.
    run_frame(16'h0003, 1'b1, pulses, lat, pd, mp);
    check("f1_pulses", 32'(pulses), 32'd1);
    check("f1_latency", 32'(lat), 32'd2);
    check("f1_pred_dir", 32'(pd), 32'd0);
    check("f1_mispredict", 32'(mp), 32'd1);
    check("f1_entry3", 32'(dut.u_pht.r_table[3]), 32'd2);
    check("f1_ghr", 32'(dut.r_ghr), 32'h1);
    check("f1_total", 32'(total_cnt), 32'd1);
    check("f1_correct", 32'(correct_cnt), 32'd0);
    check("f1_busy", 32'(busy), 32'd0);

    // Four taken frames at addr 0: GHR walks 1,3,7,F, index walks 0,1,3,7.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_frame(16'h0000, 1'b1, pulses, lat, pd, mp);
      check($sformatf("hist%0d_pred", k), 32'(pd), 32'd0);
      check($sformatf("hist%0d_miss", k), 32'(mp), 32'd1);
      check($sformatf("hist%0d_entry", k), 32'(dut.u_pht.r_table[exp_idx[k]]), 32'd2);
      check($sformatf("hist%0d_ghr", k), 32'(dut.r_ghr), 32'(exp_ghr[k]));
    end
    check("hist_total", 32'(total_cnt), 32'd4);
    check("hist_correct", 32'(correct_cnt), 32'd0);

    // Saturation: addresses chosen against the known GHR so the index stays 5.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      run_frame(sat_addr[k], 1'b1, pulses, lat, pd, mp);
      check($sformatf("sat%0d_pred", k), 32'(pd), 32'(sat_pd[k]));
      check($sformatf("sat%0d_entry5", k), 32'(dut.u_pht.r_table[5]), 32'(sat_ctr[k]));
    end
    check("sat_correct", 32'(correct_cnt), 32'd4);
    run_frame(16'h000A, 1'b0, pulses, lat, pd, mp);
    check("sat_nt_pred", 32'(pd), 32'd1);
    check("sat_nt_miss", 32'(mp), 32'd1);
    check("sat_nt_entry5", 32'(dut.u_pht.r_table[5]), 32'd2);
    check("sat_nt_ghr", 32'(dut.r_ghr), 32'hE);
    check("sat_nt_total", 32'(total_cnt), 32'd6);
    check("sat_nt_correct", 32'(correct_cnt), 32'd4);

    // Second edge during PREDICT is discarded.
    do_reset();
    drop_frame(2, pulses);
    check("dropP_pulses", 32'(pulses), 32'd1);
    check("dropP_dropped", 32'(dropped), 32'd1);
    check("dropP_total", 32'(total_cnt), 32'd1);

    // Second edge during UPDATE is discarded too, and the flag stays sticky.
    do_reset();
    drop_frame(3, pulses);
    check("dropU_pulses", 32'(pulses), 32'd1);
    check("dropU_dropped", 32'(dropped), 32'd1);
    check("dropU_total", 32'(total_cnt), 32'd1);
    run_frame(16'h0001, 1'b0, pulses, lat, pd, mp);
    check("dropU_next_pulses", 32'(pulses), 32'd1);
    check("dropU_next_total", 32'(total_cnt), 32'd2);
    check("dropU_sticky", 32'(dropped), 32'd1);

    // Reset landing in PREDICT aborts the frame.
    do_reset();
    inst_addr = 16'h0003;
    direction_ground_truth = 1'b1;
    data_input_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_input_done = 1'b0;
    @(negedge clk);
    check("abort_in_predict", 32'(pred_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_rst_valid", 32'(pred_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_total", 32'(total_cnt), 32'd0);
    check("abort_entry3", 32'(dut.u_pht.r_table[3]), 32'd1);
    check("abort_ghr", 32'(dut.r_ghr), 32'd0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (pred_valid) pulses++;
      @(negedge clk);
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);

    // Statistics saturation with the counter preloaded one short of the top.
    do_reset();
    force dut.r_total_cnt = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.r_total_cnt;
    @(negedge clk);
    check("sat_cnt_preload", 32'(total_cnt), 32'hFFFE);
    run_frame(16'h0002, 1'b0, pulses, lat, pd, mp);
    check("sat_cnt_top", 32'(total_cnt), 32'hFFFF);
    run_frame(16'h0002, 1'b0, pulses, lat, pd, mp);
    check("sat_cnt_hold", 32'(total_cnt), 32'hFFFF);
    check("sat_cnt_correct", 32'(correct_cnt), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/branch_pred_ctrl.md
BRANCH_PRED_CTRL -- requirements
Module: branch_pred_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: width of latched instruction address.
REQ-002 SHALL have parameter IDX_W, default 4: table index width; table holds 2**IDX_W entries.
REQ-003 SHALL have parameter HIST_W, default 4: global history width; legal range 1..IDX_W.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port data_input_done, input, 1 bit: SPI frame-complete level, synchronous to clk.
REQ-007 SHALL have port inst_addr, input, ADDR_W bits: branch address, stable while data_input_done is high.
REQ-008 SHALL have port direction_ground_truth, input, 1 bit: actual outcome (1 = taken), stable with inst_addr.
REQ-009 SHALL have port pred_valid, output, 1 bit: one-cycle strobe qualifying pred_dir and mispredict.
REQ-010 SHALL have port pred_dir, output, 1 bit: predicted direction (1 = taken).
REQ-011 SHALL have port mispredict, output, 1 bit: pred_dir differs from ground truth.
REQ-012 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-013 SHALL have port dropped, output, 1 bit: sticky flag for a frame edge lost while busy.
REQ-014 SHALL have ports total_cnt and correct_cnt, outputs, 16 bits each: frames processed and frames predicted correctly.

Function
REQ-015 SHALL detect a frame as a rising edge of data_input_done: high now, low on the previous clock.
REQ-016 SHALL accept an edge only in IDLE, capturing inst_addr and direction_ground_truth and moving to LOOKUP.
REQ-017 SHALL, on an edge seen outside IDLE, discard it, set dropped to 1 and leave state unaffected.
REQ-018 SHALL move LOOKUP -> PREDICT -> UPDATE -> IDLE on consecutive clocks, with no stalls or other transitions.
REQ-019 SHALL compute the index in LOOKUP as captured_addr[IDX_W-1:0] XOR zero-extended GHR, and register that entry's 2-bit counter.
REQ-020 SHALL, in PREDICT only, drive pred_valid=1, pred_dir=counter[1] and mispredict=(counter[1] != captured truth); these are 0 in every other state.
REQ-021 SHALL raise pred_valid during the second clock cycle after the capture edge, giving a latency of 2.
REQ-022 SHALL, in UPDATE, saturate the indexed counter: taken increments (max 3), not-taken decrements (min 0).
REQ-023 SHALL, in UPDATE, shift the GHR left by one, inserting captured truth at bit 0 and discarding the MSB.
REQ-024 SHALL, in UPDATE, increment total_cnt and, if no mispredict, correct_cnt; both saturate at 0xFFFF and do not wrap.
REQ-025 SHALL treat an edge arriving in the UPDATE cycle as dropped per REQ-017; it is not queued.
REQ-026 SHALL make busy combinational from state.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set state=IDLE, every table entry=2'b01, GHR=0, counters=0, dropped=0, captured regs=0, and the edge-detect register=0.
REQ-028 SHALL, on reset mid-operation, abort the frame with no table, GHR or counter update, and assert no pred_valid.
REQ-029 SHALL clear dropped only by reset.
REQ-030 SHALL hold every output at 0 while rst=1.

Structure
REQ-031 SHALL take the state enum (IDLE, LOOKUP, PREDICT, UPDATE) and counter constants (SNT=0, WNT=1, WT=2, ST=3) from shared package branch_pred_pkg.
REQ-032 SHALL place the counter table with its read port and saturating update in one sub-module, bp_pht; the FSM, GHR and statistics stay in branch_pred_ctrl.

Verification
REQ-033 SHALL check that after reset one frame (addr=0x0003, truth=1) gives pred_valid 2 cycles after the edge with pred_dir=0 and mispredict=1; then entry 3=2'b10, GHR=0x1, total=1, correct=0.
REQ-034 SHALL check that four frames addr=0x0000, truth=1, each after IDLE, give the exact sequence of indices, predictions and GHR values matching a reference model, with GHR=0xF at the end.
REQ-035 SHALL check saturation: after 5 taken frames to one fixed index with HIST_W forced via a 0-history pattern, the entry holds 3; one not-taken frame leaves 2.
REQ-036 SHALL check that a second rising edge one cycle after an accepted edge leaves dropped=1, total incremented by exactly 1 and a single pred_valid pulse.
REQ-037 SHALL check that rst asserted during PREDICT returns busy=0 on the next cycle, leaves total=0, sets table entries to 2'b01, and produces no further pred_valid.
REQ-038 SHALL check that with total_cnt preloaded via 65535 frames the next frame leaves total_cnt=0xFFFF.
